alu_share_arb: RTL and testbench

Shares one instance of the team's single-cycle alu module between NREQ requesters. Each requester issues an operation (A, B, F) over a valid/ready handshake. A round-robin arbiter grants one request at a time, and a 3-state sequencer captures the operands, executes on the ALU and returns a registered result with a requester ID. The block sits between the multicycle datapath clients (e.g. address and branch-compare units) and the shared ALU.

---
 rtl/alu_share_pkg.sv | 23 ++
 rtl/alu.sv | 29 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_share_arb.sv | 109 ++++++++++
 tb/tb_alu_share_arb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU function codes,
// sequencer states and the captured-operation record.
package alu_share_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit ALU. F[2] inverts B and adds one (subtract path);
// F[1:0] picks AND / OR / SUM / sign-of-SUM.
module alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  f_i,
    output logic [31:0] y_o,
    output logic        zero_o
);

    logic [31:0] bb;
    logic [31:0] sum;

    assign bb  = f_i[2] ? ~b_i : b_i;
    assign sum = a_i + bb + {31'b0, f_i[2]};

    always_comb begin
        y_o = '0;
        case (f_i[1:0])
            2'b00:   y_o = a_i & bb;
            2'b01:   y_o = a_i | bb;
            2'b10:   y_o = sum;
            default: y_o = {31'b0, sum[31]};
        endcase
    end

    assign zero_o = (y_o == 32'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo NREQ (NREQ need not be a power of two).
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    always_comb begin
        int          idx;
        logic [IDW-1:0] idx_w;
        logic        found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = IDW'(idx);
            if (en_i && !found && req_i[idx_w]) begin
                found        = 1'b1;
                gnt_o[idx_w] = 1'b1;
                gnt_idx_o    = idx_w;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one alu between NREQ requesters: round-robin grant in IDLE,
// execute in EXEC, hold a registered result in RESP until accepted.
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*3-1:0] req_f,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [31:0]       resp_y,
    output logic              resp_zero,
    output logic              busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] resp_id_q;
    alu_op_t        op_q;
    logic [31:0]    y_q;
    logic           zero_q;

    alu_op_t        req_op [NREQ];
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx;
    logic           arb_en;
    logic [31:0]    alu_y;
    logic           alu_zero;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_op[i] = '{a: req_a[32*i +: 32], b: req_b[32*i +: 32], f: req_f[3*i +: 3]};
    end

    // Reset gates the grant so req_ready reads zero while reset is held.
    assign arb_en = (state_q == IDLE) && !reset;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    alu u_alu (
        .a_i    (op_q.a),
        .b_i    (op_q.b),
        .f_i    (op_q.f),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = EXEC;
                    ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            resp_id_q <= '0;
            op_q      <= '0;
            y_q       <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (state_q == IDLE && |gnt) begin
                op_q <= req_op[gnt_idx];
                id_q <= gnt_idx;
            end
            if (state_q == EXEC) begin
                y_q       <= alu_y;
                zero_q    <= alu_zero;
                resp_id_q <= id_q;
            end
        end
    end

    assign req_ready  = gnt;
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = resp_id_q;
    assign resp_y     = y_q;
    assign resp_zero  = zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb (NREQ=3): directed steps plus a randomized run,
// checked against a spec-level model of grant order and ALU results.
module tb_alu_share_arb;

    localparam int NREQ = 3;
    localparam int IDW  = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                resp_ready = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a, req_b;
    logic [NREQ*3-1:0]   req_f;
    logic                resp_valid, resp_zero, busy;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_y;

    logic [31:0] a_arr [NREQ];
    logic [31:0] b_arr [NREQ];
    logic [2:0]  f_arr [NREQ];

    int passed  = 0;
    int total   = 0;
    int mdl_ptr = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_f = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = a_arr[i];
            req_b[32*i +: 32] = b_arr[i];
            req_f[3*i +: 3]   = f_arr[i];
        end
    end

    alu_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_f      (req_f),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_zero  (resp_zero),
        .busy       (busy)
    );

    // Reference ALU written from the function table.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        logic [31:0] t;
        case (f)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b011: begin t = a + b; return {31'b0, t[31]}; end
            3'b100: return a & ~b;
            3'b101: return a | ~b;
            3'b110: return a - b;
            default: begin t = a - b; return {31'b0, t[31]}; end
        endcase
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(mdl_ptr + k) % NREQ]) return (mdl_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f);
        a_arr[i] = a;
        b_arr[i] = b;
        f_arr[i] = f;
    endtask

    // One full operation starting in an IDLE cycle with req_valid already driven.
    task automatic txn(input int hold, input bit drop);
        int          g;
        logic [31:0] ey;
        logic [31:0] ez;
        @(negedge clk);
        g = model_grant();
        chk("grant_ready", 32'(req_ready), 32'(1 << g));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        ey = alu_ref(a_arr[g], b_arr[g], f_arr[g]);
        ez = (ey == 32'd0) ? 32'd1 : 32'd0;
        @(posedge clk);
        mdl_ptr = (g + 1) % NREQ;
        #1;
        if (drop) req_valid[g] = 1'b0;
        resp_ready = (hold == 0);
        @(negedge clk);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        for (int c = 0; c <= hold; c++) begin
            if (c == hold) resp_ready = 1'b1;
            @(negedge clk);
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_y", resp_y, ey);
            chk("resp_zero", 32'(resp_zero), ez);
            chk("resp_id", 32'(resp_id), 32'(g));
            chk("resp_ready_out", 32'(req_ready), 32'd0);
            chk("resp_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) set_op(i, 32'd0, 32'd0, 3'b000);

        // Reset state
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_y", resp_y, 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_zero", 32'(resp_zero), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single requester 0: ADD 5+7
        set_op(0, 32'd5, 32'd7, 3'b010);
        req_valid = 3'b001;
        txn(0, 1);

        // Single requester 1: SUB, SLT, AND, SLT with A-B overflow
        set_op(1, 32'd9, 32'd9, 3'b110);
        req_valid = 3'b010; txn(0, 1);
        set_op(1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        req_valid = 3'b010; txn(0, 1);
        set_op(1, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000);
        req_valid = 3'b010; txn(0, 1);
        set_op(1, 32'h8000_0000, 32'd1, 3'b111);
        req_valid = 3'b010; txn(0, 1);

        // All valid: strict rotation
        set_op(0, 32'd100, 32'd1, 3'b010);
        set_op(1, 32'd3, 32'd5, 3'b001);
        set_op(2, 32'd7, 32'd7, 3'b110);
        req_valid = 3'b111;
        for (int n = 0; n < 4; n++) txn(0, 0);

        // Backpressure: resp_ready low for 5 cycles
        txn(5, 0);
        txn(2, 0);

        // Reset mid-EXEC
        req_valid = 3'b010;
        set_op(1, 32'd1, 32'd2, 3'b010);
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'(1 << model_grant()));
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        req_valid = 3'b011;
        mdl_ptr = 0;
        @(posedge clk); #1;
        chk("midrst_resp_y", resp_y, 32'd0);
        chk("midrst_ready2", 32'(req_ready), 32'd0);
        reset = 1'b0;
        txn(0, 1);
        txn(0, 1);

        // Requester 2 alone (ptr wraps), then all three
        set_op(2, 32'hDEAD_0000, 32'h0000_BEEF, 3'b001);
        req_valid = 3'b100;
        txn(0, 1);
        req_valid = 3'b111;
        for (int n = 0; n < 4; n++) txn(0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                set_op(i, ra, rb, 3'($urandom_range(0, 7)));
            end
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
